gpio_reg_bank: RTL and testbench

Parametrised configuration register bank that decodes the PS-driven GPIO write bus into a contiguous block of wide configuration registers. Each register is loaded byte-serially, MSB byte first, and committed atomically. A per-register one-cycle update strobe is raised on commit. The bank sits between the GPIO bus and the DAC/ADC driver blocks, and generalises the fixed 8-bit register scheme to arbitrary register width and count.

---
 rtl/gpio_reg_bank_pkg.sv | 27 ++
 rtl/gpio_bus_sync.sv | 44 ++++
 rtl/gpio_reg_bank.sv | 168 ++++++++++++++++
 tb/tb_gpio_reg_bank.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_reg_bank_pkg.sv
// Shared GPIO bus field layout, register-bank addresses and state encoding.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Consumed by the GPIO synchroniser and by every register bank on the bus.
package ising_config;

    localparam int gpio_addr_width = 16;
    localparam int gpio_data_width = 8;
    localparam int gpio_w_clk_bit  = gpio_addr_width + gpio_data_width;
    localparam int gpio_bus_width  = gpio_w_clk_bit + 1;

    localparam int          gpio_reg_num       = 8;
    localparam logic [15:0] gpio_reg_base_addr = 16'h0030;
    localparam logic [15:0] gpio_reg_ctrl_addr = gpio_reg_base_addr + 16'(gpio_reg_num);

    // Field view of the write bus: strobe on top, data above address.
    typedef struct packed {
        logic                       w_clk;
        logic [gpio_data_width-1:0] data;
        logic [gpio_addr_width-1:0] addr;
    } gpio_word_t;

    typedef enum logic {
        IDLE,
        ACCUM
    } bank_state_t;

endpackage

// File: rtl/gpio_bus_sync.sv
// Synchronises the asynchronous GPIO write bus and detects rising edges of w_clk.
// Latency: wr_stb is high in the cycle after the SYNC_STAGES-1'th edge that sees w_clk=1.
// Backpressure: none; the host paces writes by holding w_clk high/low long enough.
module gpio_bus_sync
    import ising_config::*;
#(
    parameter int ADDR_WIDTH  = gpio_addr_width,
    parameter int DATA_WIDTH  = gpio_data_width,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0]   gpio_in,
    output logic                             wr_stb,
    output logic [ADDR_WIDTH-1:0]            wr_addr,
    output logic [DATA_WIDTH-1:0]            wr_data
);

    localparam int BUS_W = ADDR_WIDTH + DATA_WIDTH + 1;

    logic [BUS_W-1:0] sync_q [SYNC_STAGES];
    logic             w_clk_prev;

    // The whole word travels through the chain so address, data and strobe stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            w_clk_prev <= 1'b0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            w_clk_prev <= sync_q[SYNC_STAGES-1][BUS_W-1];
        end
    end

    assign wr_stb  = sync_q[SYNC_STAGES-1][BUS_W-1] & ~w_clk_prev;
    assign wr_addr = sync_q[SYNC_STAGES-1][ADDR_WIDTH-1:0];
    assign wr_data = sync_q[SYNC_STAGES-1][ADDR_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/gpio_reg_bank.sv
// Wide config register bank loaded byte-serially (MSB first) over the GPIO bus; optional readback via GPIO_REG_READBACK_EN.
// Latency: commit visible on reg_out/reg_update the cycle after edge SYNC_STAGES; rd_data one cycle after rd_addr.
// Backpressure: none; out-of-range addresses are ignored so other GPIO targets can interleave.
module gpio_reg_bank
    import ising_config::*;
#(
    parameter int                    NUM_REGS    = gpio_reg_num,
    parameter int                    REG_WIDTH   = 32,
    parameter int                    ADDR_WIDTH  = gpio_addr_width,
    parameter int                    DATA_WIDTH  = gpio_data_width,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(gpio_reg_base_addr),
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0]    gpio_in,
    output logic [NUM_REGS*REG_WIDTH-1:0]     reg_out,
    output logic [NUM_REGS-1:0]               reg_update,
    output logic                              proto_err
`ifdef GPIO_REG_READBACK_EN
    ,
    input  logic [ADDR_WIDTH-1:0]             rd_addr,
    output logic [REG_WIDTH-1:0]              rd_data
`endif
);

    localparam int BEATS = REG_WIDTH / DATA_WIDTH;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [ADDR_WIDTH:0]   END_ADDR  = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = END_ADDR[ADDR_WIDTH-1:0];

    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return off[IDX_W-1:0];
    endfunction

    logic                  wr_stb;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    gpio_bus_sync #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .gpio_in (gpio_in),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    bank_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [REG_WIDTH-1:0] stage_q, stage_d;
    logic                 err_q, err_d;
    logic                 commit;

    logic                 wr_hit;
    logic [IDX_W-1:0]     wr_idx;
    logic [REG_WIDTH-1:0] shifted;

    logic [REG_WIDTH-1:0] regs [NUM_REGS];

    assign wr_hit  = addr_hit(wr_addr);
    assign wr_idx  = addr_idx(wr_addr);
    // Staging is all-zero outside ACCUM, so the first byte shifts in cleanly.
    assign shifted = (stage_q << DATA_WIDTH) | REG_WIDTH'(wr_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        err_d   = err_q;
        commit  = 1'b0;
        if (wr_stb) begin
            if (wr_hit) begin
                if (state_q == ACCUM && wr_idx != idx_q) begin
                    // Target switched mid-word: drop the partial word, restart on the new one.
                    err_d   = 1'b1;
                    stage_d = REG_WIDTH'(wr_data);
                    cnt_d   = CNT_W'(1);
                    idx_d   = wr_idx;
                    state_d = ACCUM;
                end else if (cnt_q == CNT_W'(BEATS - 1)) begin
                    commit  = 1'b1;
                    stage_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    stage_d = shifted;
                    cnt_d   = cnt_q + CNT_W'(1);
                    idx_d   = wr_idx;
                    state_d = ACCUM;
                end
            end else if (wr_addr == CTRL_ADDR && wr_data[0]) begin
                err_d   = 1'b0;
                stage_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        end
    end

    // Committed registers only ever change by a whole word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_update <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            reg_update <= '0;
            if (commit) begin
                reg_update[wr_idx] <= 1'b1;
                regs[wr_idx]       <= shifted;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*REG_WIDTH +: REG_WIDTH] = regs[g];
    end

    assign proto_err = err_q;

`ifdef GPIO_REG_READBACK_EN
    // Reads the pre-commit value when a commit lands on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (addr_hit(rd_addr)) begin
            rd_data <= regs[addr_idx(rd_addr)];
        end else begin
            rd_data <= '0;
        end
    end
`else
    // No readback path: committed contents are visible on reg_out only.
`endif

endmodule

// File: tb/tb_gpio_reg_bank.sv
// Randomised and directed bench for gpio_reg_bank against a byte-queue reference model.
module tb_gpio_reg_bank;
    import ising_config::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [24:0]  gpio_in = '0;
    logic [255:0] reg_out;
    logic [7:0]   reg_update;
    logic         proto_err;
`ifdef GPIO_REG_READBACK_EN
    logic [15:0]  rd_addr = '0;
    logic [31:0]  rd_data;
`endif

    always #5 clk = ~clk;

    gpio_reg_bank dut (
        .clk        (clk),
        .rst        (rst),
        .gpio_in    (gpio_in),
        .reg_out    (reg_out),
        .reg_update (reg_update),
        .proto_err  (proto_err)
`ifdef GPIO_REG_READBACK_EN
        ,
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_reg [8] = '{default: '0};
    int          exp_upd [8] = '{default: 0};
    int          seen_upd [8] = '{default: 0};
    logic [7:0]  pend [$];
    int          tgt = 0;
    logic        exp_err = 1'b0;

    // Every high cycle of a strobe bit counts, so a stretched pulse shows up as an extra update.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                if (reg_update[i]) seen_upd[i]++;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_apply(input logic [15:0] a, input logic [7:0] d);
        if (a >= 16'h0030 && a < 16'h0038) begin
            int i;
            i = int'(a) - 'h30;
            if (pend.size() > 0 && i != tgt) begin
                exp_err = 1'b1;
                pend.delete();
            end
            tgt = i;
            pend.push_back(d);
            if (pend.size() == 4) begin
                exp_reg[i] = {pend[0], pend[1], pend[2], pend[3]};
                exp_upd[i]++;
                pend.delete();
            end
        end else if (a == 16'h0038 && d[0]) begin
            exp_err = 1'b0;
            pend.delete();
        end
    endtask

    task automatic check_all(input string ctx);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("%s reg%0d", ctx, i), reg_out[i*32 +: 32], exp_reg[i]);
            check_val($sformatf("%s upd_cnt%0d", ctx, i), 32'(seen_upd[i]), 32'(exp_upd[i]));
        end
        check_val($sformatf("%s proto_err", ctx), 32'(proto_err), 32'(exp_err));
    endtask

    task automatic gpio_write(input logic [15:0] a, input logic [7:0] d, input int hold);
        @(posedge clk); #1;
        gpio_in = {1'b0, d, a};
        @(posedge clk); #1;
        gpio_in[24] = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        gpio_in[24] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model_apply(a, d);
    endtask

    task automatic wr_chk(input string ctx, input logic [15:0] a, input logic [7:0] d);
        gpio_write(a, d, 3);
        check_all(ctx);
    endtask

`ifdef GPIO_REG_READBACK_EN
    task automatic rd_chk(input logic [15:0] a);
        logic [31:0] exp;
        exp = (a >= 16'h0030 && a < 16'h0038) ? exp_reg[int'(a) - 'h30] : 32'h0;
        @(posedge clk); #1;
        rd_addr = a;
        @(posedge clk); #1;
        check_val($sformatf("rd_data@%h", a), rd_data, exp);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        int          fav;
        int          r;

        #2 rst = 1'b0;
        #1;
        check_all("reset");
        check_val("reset reg_update", 32'(reg_update), 32'h0);
`ifdef GPIO_REG_READBACK_EN
        check_val("reset rd_data", rd_data, 32'h0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // Basic 4-byte load of register 1.
        wr_chk("t1b0", 16'h0031, 8'h12);
        wr_chk("t1b1", 16'h0031, 8'h34);
        wr_chk("t1b2", 16'h0031, 8'h56);
        wr_chk("t1b3", 16'h0031, 8'h78);
        check_val("t1 reg1 const", reg_out[32 +: 32], 32'h12345678);
`ifdef GPIO_REG_READBACK_EN
        rd_chk(16'h0031);
        check_val("t1 rd const", rd_data, 32'h12345678);
        rd_chk(16'h0040);
`endif

        // Mid-word address switch.
        wr_chk("t2a", 16'h0030, 8'hAA);
        wr_chk("t2b", 16'h0030, 8'hBB);
        wr_chk("t2c", 16'h0032, 8'h01);
        check_val("t2 err const", 32'(proto_err), 32'h1);
        wr_chk("t2d", 16'h0032, 8'h02);
        wr_chk("t2e", 16'h0032, 8'h03);
        wr_chk("t2f", 16'h0032, 8'h04);
        check_val("t2 reg2 const", reg_out[64 +: 32], 32'h01020304);

        // Control clear, then clean commit.
        wr_chk("t3clr", 16'h0038, 8'h01);
        wr_chk("t3a", 16'h0034, 8'hC1);
        wr_chk("t3b", 16'h0034, 8'hC2);
        wr_chk("t3c", 16'h0034, 8'hC3);
        wr_chk("t3d", 16'h0034, 8'hC4);

        // Foreign GPIO target interleaved mid-word.
        wr_chk("t4a", 16'h0033, 8'hD1);
        wr_chk("t4b", 16'h0033, 8'hD2);
        wr_chk("t4x", 16'h0005, 8'hEE);
        wr_chk("t4c", 16'h0033, 8'hD3);
        wr_chk("t4d", 16'h0033, 8'hD4);
        check_val("t4 reg3 const", reg_out[96 +: 32], 32'hD1D2D3D4);

        // Long w_clk high is a single byte.
        gpio_write(16'h0034, 8'h11, 20);
        check_all("t5hold");
        wr_chk("t5b", 16'h0034, 8'h22);
        wr_chk("t5c", 16'h0034, 8'h33);
        wr_chk("t5d", 16'h0034, 8'h44);
        check_val("t5 reg4 const", reg_out[128 +: 32], 32'h11223344);

        // Cycle-exact latency of the commit and its strobe.
        wr_chk("t6a", 16'h0035, 8'h51);
        wr_chk("t6b", 16'h0035, 8'h52);
        wr_chk("t6c", 16'h0035, 8'h53);
        @(posedge clk); #1;
        gpio_in = {1'b0, 8'h5D, 16'h0035};
`ifdef GPIO_REG_READBACK_EN
        rd_addr = 16'h0035;
`endif
        @(posedge clk); #1;
        gpio_in[24] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check_val("t6 pre upd", 32'(reg_update), 32'h0);
        check_val("t6 pre reg5", reg_out[160 +: 32], 32'h0);
        @(posedge clk); #1;
        check_val("t6 upd", 32'(reg_update), 32'h20);
        check_val("t6 reg5", reg_out[160 +: 32], 32'h5152535D);
`ifdef GPIO_REG_READBACK_EN
        check_val("t6 rd old", rd_data, 32'h0);
`endif
        @(posedge clk); #1;
        check_val("t6 post upd", 32'(reg_update), 32'h0);
`ifdef GPIO_REG_READBACK_EN
        check_val("t6 rd new", rd_data, 32'h5152535D);
`endif
        gpio_in[24] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model_apply(16'h0035, 8'h5D);
        check_all("t6end");

        // Reset mid-word with the error flag set.
        wr_chk("t7a", 16'h0037, 8'h71);
        wr_chk("t7b", 16'h0036, 8'h61);
        wr_chk("t7c", 16'h0036, 8'h62);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) exp_reg[i] = '0;
        pend.delete();
        exp_err = 1'b0;
        check_all("t7rst");
        check_val("t7rst upd", 32'(reg_update), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        wr_chk("t7d", 16'h0036, 8'hE1);
        wr_chk("t7e", 16'h0036, 8'hE2);
        wr_chk("t7f", 16'h0036, 8'hE3);
        wr_chk("t7g", 16'h0036, 8'hE4);
        check_val("t7 reg6 const", reg_out[192 +: 32], 32'hE1E2E3E4);

        // Randomised traffic.
        fav = 0;
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 11);
            d = 8'($urandom);
            if (r < 7) begin
                a = 16'h0030 + 16'(fav);
            end else if (r == 7) begin
                fav = $urandom_range(0, 7);
                a = 16'h0030 + 16'(fav);
            end else if (r == 8) begin
                a = 16'h0038;
            end else if (r == 9) begin
                a = 16'h0038;
                d[0] = 1'b0;
            end else if ($urandom_range(0, 1) == 0) begin
                a = 16'($urandom_range(0, 'h2F));
            end else begin
                a = 16'($urandom_range('h39, 'hFFFF));
            end
            gpio_write(a, d, $urandom_range(3, 6));
            check_all($sformatf("rnd%0d a=%h", n, a));
        end

`ifdef GPIO_REG_READBACK_EN
        for (int k = 'h2E; k <= 'h39; k++) rd_chk(16'(k));
        rd_chk(16'h0040);
        rd_chk(16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
